rs232c_rx_fifo: RTL



---
 rtl/rs232c_rx_fifo.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/rs232c_rx_fifo.sv
// rs232c_rx_fifo
//   RS-232C receiver with false-start rejection, optional parity, framing,
//   parity and overrun error reporting, and a first-word-fall-through
//   receive FIFO with a valid/ready pop interface.
//
// Parameters
//   CLK_PER_BIT  clocks per bit (>= 4)
//   DATA_BITS    data bits per frame (5..9)
//   PARITY       0 none, 1 even, 2 odd
//   FIFO_AW      FIFO depth is 2**FIFO_AW
//
// Ports
//   CLK          clock
//   XRST         asynchronous active-low reset
//   RS_RX        serial line, idle high, asynchronous to CLK
//   enable       gates acceptance of new start bits only
//   data         FIFO head (registered)
//   valid        FIFO head is valid (registered)
//   ready        pop the head when valid && ready
//   count        FIFO occupancy
//   frame_err    one-cycle pulse: stop bit sampled low
//   parity_err   one-cycle pulse: parity mismatch with a good stop bit
//   overrun      sticky: good frame dropped because the FIFO was full
//   clear_err    clears overrun (a simultaneous new overrun wins)
module rs232c_rx_fifo #(
   parameter int CLK_PER_BIT = 620,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int FIFO_AW     = 4
) (
   input  logic                 CLK,
   input  logic                 XRST,
   input  logic                 RS_RX,
   input  logic                 enable,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic [FIFO_AW:0]     count,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   input  logic                 clear_err
);

   localparam int TW    = $clog2(CLK_PER_BIT);
   localparam int BW    = $clog2(DATA_BITS);
   localparam int DEPTH = 1 << FIFO_AW;

   localparam logic [TW-1:0]    HALF_M1  = TW'(CLK_PER_BIT / 2 - 1);
   localparam logic [TW-1:0]    FULL_M1  = TW'(CLK_PER_BIT - 1);
   localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
   localparam logic             ODD      = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   // Outcome of a finished frame, acted on one clock after the stop sample.
   typedef struct packed {
      logic push;
      logic ferr;
      logic perr;
   } done_t;

   // ---------------------------------------------------------------------
   // Line synchronizer (idle high)
   // ---------------------------------------------------------------------
   logic rx_m, rx_s;

   always_ff @(posedge CLK or negedge XRST) begin
      if (!XRST) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= RS_RX;
         rx_s <= rx_m;
      end
   end

   // ---------------------------------------------------------------------
   // Receive FSM
   // ---------------------------------------------------------------------
   state_t               state;
   logic [TW-1:0]        tick_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_acc;   // running XOR of sampled data bits
   logic                 par_bad;
   done_t                done;
   logic                 tick_end;

   assign tick_end = (tick_cnt == FULL_M1);

   always_ff @(posedge CLK or negedge XRST) begin
      if (!XRST) begin
         state    <= S_IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_acc  <= 1'b0;
         par_bad  <= 1'b0;
         done     <= '0;
      end else begin
         done <= '0;
         case (state)
            S_IDLE: begin
               if (enable && !rx_s) begin
                  state    <= S_START;
                  tick_cnt <= '0;
               end
            end
            S_START: begin
               // Mid-start sample; a high line here was only a glitch.
               if (tick_cnt == HALF_M1) begin
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  par_acc  <= 1'b0;
                  par_bad  <= 1'b0;
                  state    <= rx_s ? S_IDLE : S_DATA;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (tick_end) begin
                  tick_cnt <= '0;
                  shreg    <= {rx_s, shreg[DATA_BITS-1:1]};   // LSB first
                  par_acc  <= par_acc ^ rx_s;
                  bit_cnt  <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT)
                     state <= (PARITY == 0) ? S_STOP : S_PARITY;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (tick_end) begin
                  tick_cnt <= '0;
                  par_bad  <= ((par_acc ^ rx_s) != ODD);
                  state    <= S_STOP;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (tick_end) begin
                  tick_cnt <= '0;
                  if (!rx_s) begin
                     // Framing error masks any parity error.
                     done.ferr <= 1'b1;
                     state     <= S_BREAK;
                  end else begin
                     done.perr <= par_bad;
                     done.push <= !par_bad;
                     state     <= S_IDLE;
                  end
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
            end
            S_BREAK: begin
               // A held-low line reports once, then waits for idle.
               if (rx_s)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge XRST) begin
      if (!XRST) begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         frame_err  <= done.ferr;
         parity_err <= done.perr;
      end
   end

   // ---------------------------------------------------------------------
   // Receive FIFO
   // ---------------------------------------------------------------------
   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
   logic [FIFO_AW:0]     cnt_vis;
   logic                 pop, full, push_ok;

   assign pop     = valid && ready;
   assign full    = (count == DEPTH_C);
   assign push_ok = done.push && (!full || pop);
   // Entries already in RAM that remain after this cycle's pop; a push in
   // this same cycle becomes visible on the head one clock later.
   assign rd_nxt  = pop ? rd_ptr + 1'b1 : rd_ptr;
   assign cnt_vis = pop ? count - 1'b1 : count;

   always_ff @(posedge CLK) begin
      if (push_ok)
         mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge CLK or negedge XRST) begin
      if (!XRST) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         valid   <= 1'b0;
         data    <= '0;
         overrun <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_nxt;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         valid <= (cnt_vis != '0);
         if (cnt_vis != '0)
            data <= mem[rd_nxt];
         if (done.push && !push_ok)
            overrun <= 1'b1;
         else if (clear_err)
            overrun <= 1'b0;
      end
   end

endmodule
